// File: rtl/control_unit_pkg.sv
// Shared definitions for the CPU control sequencer: step encodings, opcodes,
// ALU operation codes and opcode classification used by the decoder.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    C_REG, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_NOP, C_HALT, C_ILLEGAL
  } op_class_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;

  function automatic op_class_e decodeOp(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_REG;
      OP_ADDI, OP_ANDI, OP_ORI:      return C_IMM;
      OP_LDI:                        return C_LDI;
      OP_LD:                         return C_LD;
      OP_ST:                         return C_ST;
      OP_BR:                         return C_BR;
      OP_JR:                         return C_JR;
      OP_NOP:                        return C_NOP;
      OP_HALT:                       return C_HALT;
      default:                       return C_ILLEGAL;
    endcase
  endfunction

  // Address arithmetic (PC increment, displacement, branch target) always adds.
  function automatic logic [3:0] aluFor(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_wait_counter.sv
// Memory wait-state counter: loads the configured wait count, counts down
// while a memory step is being held, and flags when the step may advance.
module control_unit_wait_counter #(
  parameter logic [3:0] LOAD_VALUE = 4'd0
) (
  input  logic clock,
  input  logic clear,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [3:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (clear) count_q <= 4'd0;
    else       count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (load_i)                       count_d = LOAD_VALUE;
    else if (dec_i && count_q != 4'd0) count_d = count_q - 4'd1;
  end

  assign done_o = (count_q == 4'd0);

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, decode ir[31:27], execute T3-T7,
// with Moore-style strobes for the DataPath and memory.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout, MARin, IncPC, PCin, Zin, Zlowout, MDRin, MDRout, IRin, Yin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
  output logic        ram_read, ram_write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  state_e    state_q, state_d;
  op_class_e opClass;
  logic      inWaitStep, waitDone;
  state_e    boundary;
  logic      unusedIr;

  assign opClass    = decodeOp(ir[31:27]);
  assign unusedIr   = ^ir[26:0];
  assign inWaitStep = (state_q == S_T1) ||
                      (state_q == S_T6 && opClass == C_LD) ||
                      (state_q == S_T7 && opClass == C_ST);
  assign boundary   = stop ? S_HALT : S_T0;

  // Counter reloads in every non-memory step, so it is primed on entry to the next wait step.
  control_unit_wait_counter #(.LOAD_VALUE(4'(MEM_WAIT))) waitCounter (
    .clock (clock),
    .clear (clear),
    .load_i(!inWaitStep),
    .dec_i (inWaitStep),
    .done_o(waitDone)
  );

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    if (waitDone) state_d = S_T2;
      S_T2: begin
        case (opClass)
          C_HALT:           state_d = S_HALT;
          C_NOP, C_ILLEGAL: state_d = boundary;
          default:          state_d = S_T3;
        endcase
      end
      S_T3:    state_d = (opClass == C_JR) ? boundary : S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = (opClass == C_LD || opClass == C_ST || opClass == C_BR) ? S_T6 : boundary;
      S_T6: begin
        if (opClass == C_BR)                 state_d = boundary;
        else if (opClass != C_LD || waitDone) state_d = S_T7;
      end
      S_T7:    if (opClass != C_ST || waitDone) state_d = boundary;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    {PCout, MARin, IncPC, PCin, Zin, Zlowout, MDRin, MDRout, IRin, Yin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin} = '0;
    {ram_read, ram_write, illegal_op} = '0;
    alu_op = ALU_NOP;
    run    = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = 4'b1111;
        alu_op = ALU_ADD;
      end
      S_T1: {Zlowout, PCin, ram_read, MDRin} = 4'b1111;
      S_T2: begin
        {MDRout, IRin} = 2'b11;
        illegal_op = (opClass == C_ILLEGAL);
      end
      S_T3: begin
        case (opClass)
          C_REG, C_IMM:      {Grb, Rout, Yin} = 3'b111;
          C_LDI, C_LD, C_ST: {Grb, BAout, Yin} = 3'b111;
          C_BR:              {Gra, Rout, CONin} = 3'b111;
          C_JR:              {Gra, Rout, PCin} = 3'b111;
          default:           ;
        endcase
      end
      S_T4: begin
        if (opClass == C_BR) begin
          {PCout, Yin} = 2'b11;
        end else begin
          Zin    = 1'b1;
          alu_op = aluFor(ir[31:27]);
          if (opClass == C_REG) {Grc, Rout} = 2'b11;
          else                  Cout = 1'b1;
        end
      end
      S_T5: begin
        case (opClass)
          C_REG, C_IMM, C_LDI: {Zlowout, Gra, Rin} = 3'b111;
          C_LD, C_ST:          {Zlowout, MARin} = 2'b11;
          C_BR: begin
            {Cout, Zin} = 2'b11;
            alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (opClass)
          C_LD: {ram_read, MDRin} = 2'b11;
          C_ST: {Gra, Rout, MDRin} = 3'b111;
          C_BR: begin
            Zlowout = 1'b1;
            PCin    = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        if (opClass == C_LD)      {MDRout, Gra, Rin} = 3'b111;
        else if (opClass == C_ST) ram_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level table model builds the
// expected per-cycle strobe word for each instruction and compares it every cycle.
module tb_control_unit;
  import control_unit_pkg::ALU_ADD;
  import control_unit_pkg::ALU_SUB;
  import control_unit_pkg::ALU_AND;
  import control_unit_pkg::ALU_OR;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_BR   = 5'b10011;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [25:0] W_PCOUT = 26'd1 << 0,  W_MARIN = 26'd1 << 1,  W_INCPC = 26'd1 << 2;
  localparam logic [25:0] W_PCIN  = 26'd1 << 3,  W_ZIN   = 26'd1 << 4,  W_ZLOW  = 26'd1 << 5;
  localparam logic [25:0] W_MDRIN = 26'd1 << 6,  W_MDROUT = 26'd1 << 7, W_IRIN  = 26'd1 << 8;
  localparam logic [25:0] W_YIN   = 26'd1 << 9,  W_GRA   = 26'd1 << 10, W_GRB   = 26'd1 << 11;
  localparam logic [25:0] W_GRC   = 26'd1 << 12, W_RIN   = 26'd1 << 13, W_ROUT  = 26'd1 << 14;
  localparam logic [25:0] W_BAOUT = 26'd1 << 15, W_COUT  = 26'd1 << 16, W_CONIN = 26'd1 << 17;
  localparam logic [25:0] W_RD    = 26'd1 << 18, W_WR    = 26'd1 << 19, W_RUN   = 26'd1 << 20;
  localparam logic [25:0] W_ILL   = 26'd1 << 21;

  logic            clock = 1'b0;
  logic            clearIn [2];
  logic            conIn   [2];
  logic            stopIn  [2];
  logic [31:0]     irIn    [2];
  wire  [1:0][25:0] obs;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [25:0] expQ[$];
  logic [4:0]  legalOps [14] = '{OPC_LD, OPC_LDI, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
                                 OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_BR, OPC_JR, OPC_NOP, OPC_HALT};

  always #5 clock = ~clock;

  // Instance 0 runs with no memory wait states, instance 1 with two.
  for (genvar g = 0; g < 2; g++) begin : gDut
    control_unit #(.MEM_WAIT(g * 2)) dut (
      .clock(clock), .clear(clearIn[g]), .ir(irIn[g]), .con_ff(conIn[g]), .stop(stopIn[g]),
      .PCout(obs[g][0]), .MARin(obs[g][1]), .IncPC(obs[g][2]), .PCin(obs[g][3]),
      .Zin(obs[g][4]), .Zlowout(obs[g][5]), .MDRin(obs[g][6]), .MDRout(obs[g][7]),
      .IRin(obs[g][8]), .Yin(obs[g][9]), .Gra(obs[g][10]), .Grb(obs[g][11]),
      .Grc(obs[g][12]), .Rin(obs[g][13]), .Rout(obs[g][14]), .BAout(obs[g][15]),
      .Cout(obs[g][16]), .CONin(obs[g][17]), .ram_read(obs[g][18]), .ram_write(obs[g][19]),
      .run(obs[g][20]), .illegal_op(obs[g][21]), .alu_op(obs[g][25:22])
    );
  end

  task automatic checkOutput(input string tag, input logic [25:0] got, input logic [25:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [25:0] aluW(input logic [3:0] code);
    return {code, 22'd0};
  endfunction

  function automatic bit isLegal(input logic [4:0] op);
    foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Fills expQ with one word per clock for a whole instruction; returns 1 for HALT.
  function automatic bit buildSeq(input logic [4:0] op, input int w, input logic con);
    logic [25:0] r = W_RUN;
    expQ.delete();
    expQ.push_back(r | W_PCOUT | W_MARIN | W_INCPC | W_ZIN | aluW(ALU_ADD));
    repeat (1 + w) expQ.push_back(r | W_ZLOW | W_PCIN | W_RD | W_MDRIN);
    expQ.push_back(r | W_MDROUT | W_IRIN | (isLegal(op) ? 26'd0 : W_ILL));
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
        expQ.push_back(r | W_GRB | W_ROUT | W_YIN);
        expQ.push_back(r | W_GRC | W_ROUT | W_ZIN |
                       aluW(op == OPC_ADD ? ALU_ADD : op == OPC_SUB ? ALU_SUB :
                            op == OPC_AND ? ALU_AND : ALU_OR));
        expQ.push_back(r | W_ZLOW | W_GRA | W_RIN);
      end
      OPC_ADDI, OPC_ANDI, OPC_ORI: begin
        expQ.push_back(r | W_GRB | W_ROUT | W_YIN);
        expQ.push_back(r | W_COUT | W_ZIN |
                       aluW(op == OPC_ADDI ? ALU_ADD : op == OPC_ANDI ? ALU_AND : ALU_OR));
        expQ.push_back(r | W_ZLOW | W_GRA | W_RIN);
      end
      OPC_LDI, OPC_LD, OPC_ST: begin
        expQ.push_back(r | W_GRB | W_BAOUT | W_YIN);
        expQ.push_back(r | W_COUT | W_ZIN | aluW(ALU_ADD));
        if (op == OPC_LDI) begin
          expQ.push_back(r | W_ZLOW | W_GRA | W_RIN);
        end else if (op == OPC_LD) begin
          expQ.push_back(r | W_ZLOW | W_MARIN);
          repeat (1 + w) expQ.push_back(r | W_RD | W_MDRIN);
          expQ.push_back(r | W_MDROUT | W_GRA | W_RIN);
        end else begin
          expQ.push_back(r | W_ZLOW | W_MARIN);
          expQ.push_back(r | W_GRA | W_ROUT | W_MDRIN);
          repeat (1 + w) expQ.push_back(r | W_WR);
        end
      end
      OPC_BR: begin
        expQ.push_back(r | W_GRA | W_ROUT | W_CONIN);
        expQ.push_back(r | W_PCOUT | W_YIN);
        expQ.push_back(r | W_COUT | W_ZIN | aluW(ALU_ADD));
        expQ.push_back(r | W_ZLOW | (con ? W_PCIN : 26'd0));
      end
      OPC_JR: expQ.push_back(r | W_GRA | W_ROUT | W_PCIN);
      default: ;
    endcase
    return (op == OPC_HALT);
  endfunction

  // Runs one instruction on DUT d starting at a T0 cycle; abortAt < 0 counts from the end.
  task automatic applyStimulus(input int d, input logic [31:0] instr, input logic con,
                               input logic stopReq, input int abortAt);
    int w = d * 2;
    logic [4:0] op = instr[31:27];
    bit hlt;
    int n, ab;
    hlt = buildSeq(op, w, con);
    n   = expQ.size();
    ab  = (abortAt < 0) ? n + abortAt : abortAt;
    irIn[d]  = instr;
    conIn[d] = con;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("mw%0d op%05b step%0d", w, op, i), obs[d], expQ[i]);
      if (i == ab) begin
        clearIn[d] = 1'b1;
        @(negedge clock);
        checkOutput($sformatf("mw%0d abort reset", w), obs[d], 26'd0);
        clearIn[d] = 1'b0;
        stopIn[d]  = 1'b0;
        @(negedge clock);
        return;
      end
      stopIn[d] = (i == n - 1) ? stopReq : 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    stopIn[d] = 1'b0;
    if (hlt || stopReq) begin
      repeat (3) begin
        checkOutput($sformatf("mw%0d halt hold", w), obs[d], 26'd0);
        stopIn[d] = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      stopIn[d]  = 1'b0;
      clearIn[d] = 1'b1;
      @(negedge clock);
      checkOutput($sformatf("mw%0d halt clear", w), obs[d], 26'd0);
      clearIn[d] = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clearIn[d] = 1'b1; conIn[d] = 1'b0; stopIn[d] = 1'b0; irIn[d] = 32'd0;
    end
    for (int d = 0; d < 2; d++) begin
      clearIn[d] = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput($sformatf("mw%0d reset state", d * 2), obs[d], 26'd0);
      clearIn[d] = 1'b0;
      @(negedge clock);
      applyStimulus(d, 32'h19888000, 1'b0, 1'b0, 999);
      applyStimulus(d, 32'h09000054, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_LD, 27'h0400010}, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_BR, 27'h0800004}, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_BR, 27'h0800004}, 1'b1, 1'b0, 999);
      applyStimulus(d, {OPC_JR, 27'h1000000}, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_ST, 27'h0400020}, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_NOP, 27'd0}, 1'b0, 1'b0, 999);
      applyStimulus(d, {5'b11111, 27'd0}, 1'b0, 1'b0, 999);
      applyStimulus(d, {OPC_ST, 27'h0400020}, 1'b0, 1'b0, -2);
      applyStimulus(d, 32'h19888000, 1'b0, 1'b1, 999);
      applyStimulus(d, {OPC_HALT, 27'd0}, 1'b0, 1'b0, 999);
      for (int k = 0; k < 80; k++) begin
        logic [4:0] op;
        int ab;
        if ($urandom_range(0, 15) == 0) begin
          do op = 5'($urandom); while (isLegal(op));
        end else begin
          op = legalOps[$urandom_range(0, 13)];
        end
        ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16)) : 999;
        applyStimulus(d, {op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), ab);
      end
      clearIn[d] = 1'b1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
